alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU (AND / ADD / SUB, 2-bit ctrl, Result + Overflow).
- Accepts operation requests over per-requester valid/ready handshakes and selects a winner round-robin.
- Registers the winner's operands onto the ALU inputs and captures the ALU result one cycle later.
- Returns the result with a requester ID over a valid/ready response channel.
- Sits between the two datapath clients and a single externally instantiated ALU.

## Interface
Parameters:
- None; widths are fixed by the ALU (4-bit operands, 2-bit ctrl).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_opA, req0_opB  input  4 each  requester 0 operands
- req0_ctrl  input  2  requester 0 op: 00 AND, 01 ADD, 10 AND, 11 SUB
- req1_valid, req1_ready, req1_opA, req1_opB, req1_ctrl  same as requester 0, for requester 1
- alu_opA, alu_opB  output  4 each  registered operands to ALU
- alu_ctrl  output  2  registered ctrl to ALU
- alu_Result  input  4  ALU result (combinational from alu_* outputs)
- alu_Overflow  input  1  ALU overflow
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op
- rsp_Result  output  4  captured result
- rsp_Overflow  output  1  captured overflow
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Compute grant combinationally from the valids and the last-grant pointer `last`.
  - Assert reqN_ready for the granted requester only.
  - On valid&ready: latch opA/opB/ctrl into the alu_* registers, latch the ID, update `last`, go to EXEC.
  - No valid: stay in IDLE; alu_* hold their values.
- **EXEC (exactly 1 cycle):**
  - The ALU settles from the registered inputs.
  - At the end of the cycle, capture alu_Result/alu_Overflow into rsp_Result/rsp_Overflow and go to RESP.
- **RESP:**
  - rsp_valid=1; rsp_* stable.
  - On rsp_ready=1, go to IDLE.
- **Grant rules:**
  - Only one valid: that requester wins.
  - Both valid: winner = !last.
  - `last` resets to 1, so requester 0 wins the first tie.
- Both ready outputs are 0 outside IDLE; a requester must hold valid and its operands stable until ready.
- Overflow is passed through unmodified; the ALU already gates it to ADD/SUB.
- **Reset (any state, including mid-EXEC or RESP):**
  - FSM → IDLE; in-flight op is dropped with no response.
  - Outputs: alu_opA/opB/ctrl=0, rsp_valid=0, rsp_id=0, rsp_Result=0, rsp_Overflow=0, req*_ready=0 during rst, busy=0, last=1.

## Timing
- Accept edge at cycle N.
- EXEC during cycle N+1.
- rsp_valid high from cycle N+2.
- Minimum issue interval: 3 cycles, when rsp_ready is held at 1.
- req*_ready is combinational from req*_valid and state; this is the only combinational input→output path.
- rsp_ready low holds RESP indefinitely; no new grant occurs until the response is consumed.
- A response handshake at edge M returns the FSM to IDLE; a new grant is possible in cycle M+1 (accept at edge M+1).

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are valid; `last` is still updated but ignored.
  - Undefined (default): round-robin as described above.

## Test plan
- req0 ADD opA=0111, opB=0001, rsp_ready=1 → rsp_valid at N+2 with rsp_id=0, Result=1000, Overflow=1; busy high for 2 cycles.
- req1 SUB opA=0011, opB=0101 → Result=1110, Overflow=0, rsp_id=1; req1 AND 1100&1010 → Result=1000, Overflow=0.
- Both valid continuously, four ops each side → grants alternate in order 0,1,0,1,… and rsp_id alternates likewise.
  - With `ALU_ARB_FIXED_PRIO_EN` defined: all requester-0 ops are served first.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, req0_ready=req1_ready=0 throughout; when rsp_ready rises, next grant is one cycle later.
- rst pulsed during EXEC → no rsp_valid; all outputs return to reset values; the next request behaves like the first after reset (req0 wins the tie).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Two-requester arbiter and sequencer in front of a single, externally
//   instantiated 4-bit ALU (AND / ADD / SUB). A winner is chosen round-robin,
//   its operands are registered onto the ALU inputs, the ALU result is captured
//   one cycle later and returned with the requester ID over a valid/ready
//   response channel.
//
//   Build option:
//     ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                            undefined -> round-robin tie break (default)
//
//   Timing: accept edge N, EXEC during N+1, rsp_valid from N+2. The ready
//   outputs are the only combinational input-to-output path.

module alu_share_arbiter (
    input  logic       clk,
    input  logic       rst,

    // Requester 0
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_opA,
    input  logic [3:0] req0_opB,
    input  logic [1:0] req0_ctrl,

    // Requester 1
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_opA,
    input  logic [3:0] req1_opB,
    input  logic [1:0] req1_ctrl,

    // Shared ALU
    output logic [3:0] alu_opA,
    output logic [3:0] alu_opB,
    output logic [1:0] alu_ctrl,
    input  logic [3:0] alu_Result,
    input  logic       alu_Overflow,

    // Response channel
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_Result,
    output logic       rsp_Overflow,

    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Last granted requester ID; resets to 1 so requester 0 wins the first tie.
    logic   last;
    logic   grant0;
    logic   grant1;
    logic   accept;

    // Arbitration: choose a winner among the currently valid requesters.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no latch can be inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            // Fixed priority: requester 0 always wins; last is tracked but unused.
            grant0 = 1'b1;
`else
            // Round-robin: the requester that did not win last time goes first.
            grant0 = last;
            grant1 = ~last;
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Next-state logic and handshake/status outputs of the sequencer.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                // Ready is suppressed while reset is held.
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                accept     = (grant0 | grant1) & ~rst;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // ALU settles from the registered operands this cycle.
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight operation without a response.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers, requester ID and round-robin pointer, loaded on accept.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all of these registers drive outputs directly, so each one gets an explicit reset value.
        if (rst) begin
            alu_opA  <= 4'd0;
            alu_opB  <= 4'd0;
            alu_ctrl <= 2'd0;
            rsp_id   <= 1'b0;
            last     <= 1'b1;
        end else if (accept) begin
            if (grant1) begin
                alu_opA  <= req1_opA;
                alu_opB  <= req1_opB;
                alu_ctrl <= req1_ctrl;
            end else begin
                alu_opA  <= req0_opA;
                alu_opB  <= req0_opB;
                alu_ctrl <= req0_ctrl;
            end
            rsp_id <= grant1;
            last   <= grant1;
        end
    end

    // Capture the settled ALU outputs at the end of the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_Result   <= 4'd0;
            rsp_Overflow <= 1'b0;
        end else if (state == EXEC) begin
            rsp_Result   <= alu_Result;
            rsp_Overflow <= alu_Overflow;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter. Provides the shared ALU, a transaction-level
//   reference model (free/busy plus cycles since accept) compared against the
//   DUT on every falling edge, and directed tests with hand-computed literals.
//   Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.

module tb_alu_share_arbiter;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
    } op_t;

    typedef struct packed {
        logic       id;
        logic [3:0] r;
        logic       ov;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_opA, req0_opB, req1_opA, req1_opB;
    logic [1:0] req0_ctrl, req1_ctrl;
    logic [3:0] alu_opA, alu_opB, alu_Result;
    logic [1:0] alu_ctrl;
    logic       alu_Overflow;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_Overflow, busy;
    logic [3:0] rsp_Result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t rsp_log[$];
    int   acc_log[$];
    int   hs_log[$];
    int   busy_cnt;
    logic hs0 = 1'b0;
    logic hs1 = 1'b0;

    // Reference model state
    logic       m_free = 1'b1;
    logic       m_last = 1'b1;
    int         m_exec_cyc;
    logic       m_id;
    logic [3:0] m_a, m_b, m_res;
    logic [1:0] m_c;
    logic       m_ov;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_ctrl(req1_ctrl),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_ctrl(alu_ctrl),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_Result(rsp_Result), .rsp_Overflow(rsp_Overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU from signed integer arithmetic: 00/10 AND, 01 ADD, 11 SUB.
    function automatic logic [4:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] c);
        int sa, sb, s;
        logic [3:0] r;
        logic ov;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        if (c == 2'b01 || c == 2'b11) begin
            s  = (c == 2'b01) ? sa + sb : sa - sb;
            r  = 4'(s);
            ov = (s > 7) || (s < -8);
        end else begin
            r  = a & b;
            ov = 1'b0;
        end
        return {ov, r};
    endfunction

    assign {alu_Overflow, alu_Result} = alu_eval(alu_opA, alu_opB, alu_ctrl);

    function automatic op_t mk(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
        op_t o;
        o.a = a;
        o.b = b;
        o.c = c;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requester drivers: present queue heads, pop after an observed handshake.
    initial begin : drivers
        forever begin
            @(posedge clk);
            #2;
            if (hs0 && q0.size() != 0) void'(q0.pop_front());
            if (hs1 && q1.size() != 0) void'(q1.pop_front());
            req0_valid = (q0.size() != 0);
            if (req0_valid) begin
                req0_opA = q0[0].a; req0_opB = q0[0].b; req0_ctrl = q0[0].c;
            end
            req1_valid = (q1.size() != 0);
            if (req1_valid) begin
                req1_opA = q1[0].a; req1_opB = q1[0].b; req1_ctrl = q1[0].c;
            end
        end
    end

    // Compare process: model prediction vs DUT on every falling edge.
    initial begin : compare
        logic e_r0, e_r1, in_resp, prefer0;
        logic [4:0] ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_ready0", req0_ready, 0);
                check("rst_ready1", req1_ready, 0);
                check("rst_busy", busy, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_alu_ops", {alu_opA, alu_opB, alu_ctrl}, 0);
                check("rst_rsp_fields", {rsp_id, rsp_Result, rsp_Overflow}, 0);
                m_free = 1'b1; m_last = 1'b1;
                m_a = 4'd0; m_b = 4'd0; m_c = 2'd0;
                hs0 = 1'b0; hs1 = 1'b0;
            end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                prefer0 = 1'b1;
`else
                prefer0 = m_last;
`endif
                e_r0 = 1'b0; e_r1 = 1'b0; in_resp = 1'b0;
                if (m_free) begin
                    e_r0 = req0_valid && (!req1_valid || prefer0);
                    e_r1 = req1_valid && !e_r0;
                    check("busy", busy, 0);
                    check("rsp_valid", rsp_valid, 0);
                end else begin
                    in_resp = (cyc > m_exec_cyc);
                    check("busy", busy, 1);
                    check("rsp_valid", rsp_valid, in_resp);
                    if (in_resp) begin
                        check("rsp_id", rsp_id, m_id);
                        check("rsp_Result", rsp_Result, m_res);
                        check("rsp_Overflow", rsp_Overflow, m_ov);
                    end
                end
                check("req0_ready", req0_ready, e_r0);
                check("req1_ready", req1_ready, e_r1);
                check("alu_ops", {alu_opA, alu_opB, alu_ctrl}, {m_a, m_b, m_c});

                hs0 = req0_valid & req0_ready;
                hs1 = req1_valid & req1_ready;
                if (hs0 || hs1) acc_log.push_back(cyc);
                if (rsp_valid && rsp_ready) begin
                    rsp_log.push_back({rsp_id, rsp_Result, rsp_Overflow});
                    hs_log.push_back(cyc);
                end
                if (busy) busy_cnt++;

                // Advance the model to the next cycle.
                if (m_free && (e_r0 || e_r1)) begin
                    m_free     = 1'b0;
                    m_exec_cyc = cyc + 1;
                    m_id       = e_r1;
                    m_last     = e_r1;
                    m_a = e_r1 ? req1_opA  : req0_opA;
                    m_b = e_r1 ? req1_opB  : req0_opB;
                    m_c = e_r1 ? req1_ctrl : req0_ctrl;
                    ev  = alu_eval(m_a, m_b, m_c);
                    m_res = ev[3:0];
                    m_ov  = ev[4];
                end else if (!m_free && in_resp && rsp_ready) begin
                    m_free = 1'b1;
                end
            end
        end
    end

    task automatic clear_logs();
        rsp_log.delete();
        acc_log.delete();
        hs_log.delete();
        busy_cnt = 0;
    endtask

    // Wait (bounded) until both queues are drained and the model is idle.
    task automatic wait_idle(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !m_free) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", name, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Bounded wait for a DUT output level, sampled 1 time unit after the edge.
    task automatic wait_for(input string name, input logic sel_busy);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(sel_busy ? busy : rsp_valid) && n < 50);
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no event expected one within 50 cycles", name);
        end
    endtask

    initial begin : tests
        logic exp_id;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_opA = 4'd0; req0_opB = 4'd0; req0_ctrl = 2'd0;
        req1_valid = 1'b0; req1_opA = 4'd0; req1_opB = 4'd0; req1_ctrl = 2'd0;

        // Test 1: reset, then req0 ADD 0111+0001 (valid raised while reset held)
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        q0.push_back(mk(4'b0111, 4'b0001, 2'b01));
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("t1");
        check("t1_count", rsp_log.size(), 1);
        if (rsp_log.size() == 1) begin
            check("t1_id", rsp_log[0].id, 0);
            check("t1_result", rsp_log[0].r, 4'b1000);
            check("t1_overflow", rsp_log[0].ov, 1);
        end
        check("t1_busy_cycles", busy_cnt, 2);

        // Test 2: req1 SUB 0011-0101, then req1 AND 1100&1010 (ctrl 10)
        clear_logs();
        q1.push_back(mk(4'b0011, 4'b0101, 2'b11));
        q1.push_back(mk(4'b1100, 4'b1010, 2'b10));
        wait_idle("t2");
        check("t2_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("t2_sub", rsp_log[0], {1'b1, 4'b1110, 1'b0});
            check("t2_and", rsp_log[1], {1'b1, 4'b1000, 1'b0});
        end
        if (acc_log.size() == 2) check("t2_issue_interval", acc_log[1] - acc_log[0], 3);

        // Test 3: both valid continuously, four ops each
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'(i), 4'(i + 3), 2'b01));
            q1.push_back(mk(4'(i + 5), 4'(2 * i), 2'b11));
        end
        wait_idle("t3");
        check("t3_count", rsp_log.size(), 8);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = (i >= 4);
`else
            exp_id = i[0];
`endif
            check($sformatf("t3_id_order[%0d]", i), rsp_log[i].id, exp_id);
        end
        for (int i = 1; i < acc_log.size(); i++)
            check($sformatf("t3_interval[%0d]", i), acc_log[i] - acc_log[i - 1], 3);

        // Test 4: rsp_ready held low for 5 RESP cycles, second requester waiting
        clear_logs();
        rsp_ready = 1'b0;
        q0.push_back(mk(4'b0101, 4'b0110, 2'b01));
        q1.push_back(mk(4'b0010, 4'b1001, 2'b00));
        wait_for("t4_rsp", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("t4");
        check("t4_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("t4_first", rsp_log[0], {1'b0, 4'b1011, 1'b1});
            check("t4_second", rsp_log[1], {1'b1, 4'b0000, 1'b0});
        end
        if (acc_log.size() == 2 && hs_log.size() == 2) begin
            check("t4_stall_length", hs_log[0] - acc_log[0], 7);
            check("t4_regrant_delay", acc_log[1] - hs_log[0], 1);
        end

        // Test 5: reset pulsed during EXEC, then a tie must go to requester 0
        clear_logs();
        q0.push_back(mk(4'b0001, 4'b0001, 2'b01));
        wait_for("t5_exec", 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_dropped", rsp_log.size(), 0);
        q0.push_back(mk(4'b0100, 4'b0100, 2'b01));
        q1.push_back(mk(4'b1000, 4'b1000, 2'b11));
        wait_idle("t5");
        check("t5_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("t5_first", rsp_log[0], {1'b0, 4'b1000, 1'b1});
            check("t5_second", rsp_log[1], {1'b1, 4'b0000, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
